drbe_packet_receiver: RTL and testbench

Destination-side endpoint of the local-controller packet ring: consumes the 40-bit normal and prefetch packet streams emitted by `local_controller_prefetch_full`, filters them by this node's bit in the destination address vector and buffers accepted sample pairs in a FIFO. It serializes the pairs into a 16-bit sample stream for the compute array with a valid/ready handshake. It sits one per compute node, alongside the ring of local controllers.

---
 rtl/drbe_pkt_pkg.sv | 31 +++
 rtl/drbe_sync_fifo.sv | 58 +++++
 rtl/drbe_packet_receiver.sv | 152 +++++++++++++++
 tb/tb_drbe_packet_receiver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/drbe_pkt_pkg.sv
// Shared packet layout, serializer encoding and helpers for the DRBE packet receiver.
// Offsets describe the default 16-bit sample / 8-bit vector packet {dest_vec, sample1, sample0}.
package drbe_pkt_pkg;

  localparam int DATAWIDTH      = 16;
  localparam int ADDR_VEC_WIDTH = 8;

  function automatic int packet_width_of(input int dw, input int avw);
    return 2 * dw + avw;
  endfunction

  localparam int PACKET_WIDTH = packet_width_of(DATAWIDTH, ADDR_VEC_WIDTH);

  localparam int S0_LSB   = 0;
  localparam int S0_MSB   = DATAWIDTH - 1;
  localparam int S1_LSB   = DATAWIDTH;
  localparam int S1_MSB   = 2 * DATAWIDTH - 1;
  localparam int DEST_LSB = 2 * DATAWIDTH;
  localparam int DEST_MSB = PACKET_WIDTH - 1;

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } ser_state_t;

  // Vector is zero-extended by the caller, so any node index below 32 is legal.
  function automatic logic dest_hit(input logic [31:0] vec, input int idx);
    return vec[idx];
  endfunction

endpackage

// File: rtl/drbe_sync_fifo.sv
// Single-clock FIFO with occupancy count; write-at-edge, head visible the cycle after a push into empty.
// Pushes while full and pops while empty are ignored; flush empties it at the next edge.
module drbe_sync_fifo #(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [width-1:0]         push_dat,
  input  logic                     pop,
  output logic [width-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [ptr_w-1:0] ptr_one = 1;
  localparam logic [cnt_w-1:0] cnt_one = 1;
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr, rd_ptr;
  logic [cnt_w-1:0] cnt;
  logic             do_push, do_pop;

  assign full     = (cnt == depth_c);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign head_dat = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_one;
      if (do_pop)  rd_ptr <= rd_ptr + ptr_one;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + cnt_one;
        2'b01:   cnt <= cnt - cnt_one;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; the count alone defines what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/drbe_packet_receiver.sv
// Ring endpoint: filters normal/prefetch packets by node bit, buffers sample pairs, serializes to 16-bit stream.
// Hit at edge N shows on sample_out in cycle N+1; ready low holds sample_out, full FIFO drops packets (sticky overflow).
module drbe_packet_receiver
  import drbe_pkt_pkg::*;
#(
  parameter int datawidth            = DATAWIDTH,
  parameter int address_vector_width = ADDR_VEC_WIDTH,
  parameter int node_index           = 0,
  parameter int fifo_depth           = 8,
  parameter int packet_width         = packet_width_of(datawidth, address_vector_width)
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [packet_width-1:0] packet_in,
  input  logic                    packet_in_valid,
  input  logic [packet_width-1:0] prefetch_packet_in,
  input  logic                    prefetch_packet_in_valid,
  input  logic                    scenario_update,
  output logic [datawidth-1:0]    sample_out,
  output logic                    sample_out_valid,
  input  logic                    sample_out_ready,
  output logic                    overflow,
  output logic [15:0]             packet_count
);

  localparam int pair_w   = 2 * datawidth;
  localparam int cnt_w    = $clog2(fifo_depth) + 1;
  localparam int dest_lsb = 2 * datawidth;

  logic [address_vector_width-1:0] norm_dest, pf_dest;
  logic [pair_w-1:0]               norm_pair, pf_pair, hold_dat, push_dat, head_dat;
  logic                            norm_hit, pf_hit, hold_vld;
  logic                            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [cnt_w-1:0]                fifo_count;
  logic                            hold_load, hold_clear, drop;
  logic [1:0]                      accept_cnt;
  logic [16:0]                     count_sum;
  ser_state_t                      state, state_nxt;

  assign norm_dest = packet_in[dest_lsb +: address_vector_width];
  assign pf_dest   = prefetch_packet_in[dest_lsb +: address_vector_width];
  assign norm_pair = packet_in[pair_w-1:0];
  assign pf_pair   = prefetch_packet_in[pair_w-1:0];
  assign norm_hit  = packet_in_valid && dest_hit(32'(norm_dest), node_index);
  assign pf_hit    = prefetch_packet_in_valid && dest_hit(32'(pf_dest), node_index);

  // Admission: normal traffic owns the single push port; the hold drains, or a prefetch
  // bypasses it, only on cycles the normal stream leaves the port idle and there is room.
  always_comb begin
    fifo_push  = 1'b0;
    push_dat   = norm_pair;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    drop       = 1'b0;
    accept_cnt = 2'd0;

    if (norm_hit) begin
      if (!fifo_full) begin
        fifo_push  = 1'b1;
        accept_cnt = accept_cnt + 2'd1;
      end else begin
        drop = 1'b1;
      end
    end

    if (!norm_hit && !fifo_full && hold_vld) begin
      fifo_push  = 1'b1;
      push_dat   = hold_dat;
      hold_clear = 1'b1;
    end

    if (pf_hit) begin
      if (!norm_hit && !fifo_full && !hold_vld) begin
        fifo_push  = 1'b1;
        push_dat   = pf_pair;
        accept_cnt = accept_cnt + 2'd1;
      end else if (!hold_vld || hold_clear) begin
        hold_load  = 1'b1;
        accept_cnt = accept_cnt + 2'd1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset || scenario_update) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (hold_load) begin
      hold_vld <= 1'b1;
      hold_dat <= pf_pair;
    end else if (hold_clear) begin
      hold_vld <= 1'b0;
    end
  end

  assign count_sum = {1'b0, packet_count} + 17'(accept_cnt);

  always_ff @(posedge CLK) begin
    if (reset || scenario_update) begin
      overflow     <= 1'b0;
      packet_count <= '0;
    end else begin
      overflow     <= overflow | drop;
      packet_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end

  drbe_sync_fifo #(
    .width (pair_w),
    .depth (fifo_depth)
  ) u_pair_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .flush    (scenario_update),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (reset || scenario_update) state <= LO;
    else                          state <= state_nxt;
  end

  // Head only moves on the HI handshake, so a stalled sample stays put.
  always_comb begin
    state_nxt        = state;
    fifo_pop         = 1'b0;
    sample_out_valid = !fifo_empty;
    sample_out       = '0;
    if (!fifo_empty) begin
      sample_out = (state == HI) ? head_dat[pair_w-1:datawidth] : head_dat[datawidth-1:0];
    end
    if (sample_out_valid && sample_out_ready) begin
      case (state)
        LO:      state_nxt = HI;
        HI: begin
          state_nxt = LO;
          fifo_pop  = 1'b1;
        end
        default: state_nxt = LO;
      endcase
    end
  end

endmodule

// File: tb/tb_drbe_packet_receiver.sv
// Directed bench for drbe_packet_receiver (node 3, depth 8) with hand-computed expectations.
module tb_drbe_packet_receiver;

  logic        CLK = 1'b0;
  logic        reset;
  logic [39:0] packet_in;
  logic        packet_in_valid;
  logic [39:0] prefetch_packet_in;
  logic        prefetch_packet_in_valid;
  logic        scenario_update;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic        sample_out_ready;
  logic        overflow;
  logic [15:0] packet_count;

  int tests = 0;
  int fails = 0;

  drbe_packet_receiver #(
    .datawidth            (16),
    .address_vector_width (8),
    .node_index           (3),
    .fifo_depth           (8)
  ) dut (
    .CLK                      (CLK),
    .reset                    (reset),
    .packet_in                (packet_in),
    .packet_in_valid          (packet_in_valid),
    .prefetch_packet_in       (prefetch_packet_in),
    .prefetch_packet_in_valid (prefetch_packet_in_valid),
    .scenario_update          (scenario_update),
    .sample_out               (sample_out),
    .sample_out_valid         (sample_out_valid),
    .sample_out_ready         (sample_out_ready),
    .overflow                 (overflow),
    .packet_count             (packet_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are observed 1ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    packet_in                = '0;
    packet_in_valid          = 1'b0;
    prefetch_packet_in       = '0;
    prefetch_packet_in_valid = 1'b0;
    scenario_update          = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send_normal(input logic [39:0] pkt);
    packet_in       = pkt;
    packet_in_valid = 1'b1;
    step();
    packet_in_valid = 1'b0;
  endtask

  initial begin
    sample_out_ready = 1'b1;
    apply_reset();

    // Reset state
    check("rst_valid", 64'(sample_out_valid), 64'd0);
    check("rst_sample", 64'(sample_out), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_count", 64'(packet_count), 64'd0);

    // Single hit, serialized low then high
    send_normal(40'h08_1234_5678);
    check("t1_valid", 64'(sample_out_valid), 64'd1);
    check("t1_lo", 64'(sample_out), 64'h5678);
    check("t1_count", 64'(packet_count), 64'd1);
    step();
    check("t1_hi", 64'(sample_out), 64'h1234);
    step();
    check("t1_done", 64'(sample_out_valid), 64'd0);

    // Miss: bit 3 clear
    send_normal(40'h04_1111_2222);
    check("t2_valid", 64'(sample_out_valid), 64'd0);
    check("t2_count", 64'(packet_count), 64'd1);
    check("t2_overflow", 64'(overflow), 64'd0);

    // Normal and prefetch in the same cycle: prefetch parks, then follows
    apply_reset();
    packet_in                = 40'hFF_AAAA_BBBB;
    packet_in_valid          = 1'b1;
    prefetch_packet_in       = 40'h08_CCCC_DDDD;
    prefetch_packet_in_valid = 1'b1;
    step();
    idle_inputs();
    check("t3_count", 64'(packet_count), 64'd2);
    check("t3_s0", 64'(sample_out), 64'hBBBB);
    step();
    check("t3_s1", 64'(sample_out), 64'hAAAA);
    step();
    check("t3_s2", 64'(sample_out), 64'hDDDD);
    step();
    check("t3_s3", 64'(sample_out), 64'hCCCC);
    step();
    check("t3_done", 64'(sample_out_valid), 64'd0);

    // Fill to depth with ready low; ninth hit overflows
    apply_reset();
    sample_out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_normal({8'h08, 16'h2000 + 16'(i), 16'h1000 + 16'(i)});
      if (i == 7) begin
        check("t4_ovf_at8", 64'(overflow), 64'd0);
        check("t4_count_at8", 64'(packet_count), 64'd8);
      end
    end
    check("t4_ovf_at9", 64'(overflow), 64'd1);
    check("t4_count_at9", 64'(packet_count), 64'd8);
    sample_out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      logic [15:0] exp_s;
      exp_s = (j % 2 == 0) ? 16'h1000 + 16'(j / 2) : 16'h2000 + 16'(j / 2);
      check($sformatf("t4_valid%0d", j), 64'(sample_out_valid), 64'd1);
      check($sformatf("t4_s%0d", j), 64'(sample_out), 64'(exp_s));
      step();
    end
    check("t4_drained", 64'(sample_out_valid), 64'd0);

    // Stall stability and lossless release
    apply_reset();
    sample_out_ready = 1'b0;
    send_normal(40'h08_0B0B_0A0A);
    send_normal(40'h08_0D0D_0C0C);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t5_hold%0d", k), 64'(sample_out), 64'h0A0A);
      step();
    end
    sample_out_ready = 1'b1;
    check("t5_a_lo", 64'(sample_out), 64'h0A0A);
    step();
    check("t5_a_hi", 64'(sample_out), 64'h0B0B);
    step();
    sample_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5_mid%0d", k), 64'(sample_out), 64'h0C0C);
      step();
    end
    sample_out_ready = 1'b1;
    check("t5_b_lo", 64'(sample_out), 64'h0C0C);
    step();
    check("t5_b_hi", 64'(sample_out), 64'h0D0D);
    step();
    check("t5_done", 64'(sample_out_valid), 64'd0);

    // Flush with buffered pairs, a held prefetch, overflow set and a coincident hit
    apply_reset();
    sample_out_ready         = 1'b0;
    packet_in                = 40'h08_0101_0100;
    packet_in_valid          = 1'b1;
    prefetch_packet_in       = 40'h08_0303_0300;
    prefetch_packet_in_valid = 1'b1;
    step();
    packet_in          = 40'h08_0202_0200;
    prefetch_packet_in = 40'h08_0404_0400;
    step();
    prefetch_packet_in_valid = 1'b0;
    packet_in                = 40'h08_0505_0500;
    step();
    check("t6_pre_count", 64'(packet_count), 64'd4);
    check("t6_pre_ovf", 64'(overflow), 64'd1);
    packet_in       = 40'h08_0909_0900;
    scenario_update = 1'b1;
    step();
    idle_inputs();
    check("t6_valid", 64'(sample_out_valid), 64'd0);
    check("t6_count", 64'(packet_count), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    sample_out_ready = 1'b1;
    step();
    step();
    check("t6_still_empty", 64'(sample_out_valid), 64'd0);
    send_normal(40'h08_7777_6666);
    check("t6_fresh_lo", 64'(sample_out), 64'h6666);
    check("t6_fresh_count", 64'(packet_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
